// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and counter sizing for the PLL reset sequencer
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RELEASE_SDR,
      RUN,
      FAULT
   } seq_state_t;

   // One down-counter serves every timed state, so it is sized for the longest interval.
   function automatic int cnt_width(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchronizer for a single asynchronous level
module bit_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset/lock qualification and ordered SDRAM/system reset release
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES        = 16,
   parameter int LOCK_TIMEOUT      = 65536,
   parameter int STABLE_CYCLES     = 1024,
   parameter int SDR_TO_SYS_CYCLES = 256,
   parameter int MAX_RETRIES       = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sdr_reset,
   output logic       sys_reset,
   output logic       relock_ack,
   output logic       pll_ok,
   output logic       fault,
   output logic [2:0] retry_count
);

   localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, SDR_TO_SYS_CYCLES);

   localparam logic [CW-1:0] LD_RST     = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] LD_TIMEOUT = CW'(LOCK_TIMEOUT - 1);
   // The WAIT_LOCK cycle that saw lock already counts as the first stable cycle.
   localparam logic [CW-1:0] LD_STABLE  = CW'(STABLE_CYCLES - 2);
   localparam logic [CW-1:0] LD_SDR     = CW'(SDR_TO_SYS_CYCLES - 1);

   seq_state_t    state;
   logic [CW-1:0] cnt;
   logic          locked_s;
   logic          fail_ev;

   bit_sync u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .d     (locked),
      .q     (locked_s)
   );

   always_comb begin
      fail_ev = 1'b0;
      case (state)
         WAIT_LOCK: fail_ev = !locked_s && (cnt == '0);
         STABLE:    fail_ev = !locked_s;
         RUN:       fail_ev = !locked_s;
         default:   fail_ev = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RESET_PLL;
         cnt         <= LD_RST;
         pll_rst     <= 1'b1;
         sdr_reset   <= 1'b1;
         sys_reset   <= 1'b1;
         relock_ack  <= 1'b0;
         pll_ok      <= 1'b0;
         fault       <= 1'b0;
         retry_count <= 3'd0;
      end else begin
         relock_ack <= 1'b0;
         if (fail_ev) begin
            pll_rst   <= 1'b1;
            sdr_reset <= 1'b1;
            sys_reset <= 1'b1;
            pll_ok    <= 1'b0;
            if (retry_count == 3'(MAX_RETRIES)) begin
               state <= FAULT;
               fault <= 1'b1;
            end else begin
               state       <= RESET_PLL;
               cnt         <= LD_RST;
               retry_count <= (retry_count == 3'd7) ? 3'd7 : retry_count + 3'd1;
            end
         end else begin
            case (state)
               RESET_PLL: begin
                  if (cnt == '0) begin
                     state   <= WAIT_LOCK;
                     cnt     <= LD_TIMEOUT;
                     pll_rst <= 1'b0;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               WAIT_LOCK: begin
                  if (locked_s) begin
                     state <= STABLE;
                     cnt   <= LD_STABLE;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               STABLE: begin
                  if (cnt == '0) begin
                     state     <= RELEASE_SDR;
                     cnt       <= LD_SDR;
                     sdr_reset <= 1'b0;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               RELEASE_SDR: begin
                  if (cnt == '0) begin
                     state       <= RUN;
                     sys_reset   <= 1'b0;
                     pll_ok      <= 1'b1;
                     retry_count <= 3'd0;
                  end else begin
                     cnt <= cnt - CW'(1);
                  end
               end
               RUN: begin
                  if (relock_req) begin
                     state      <= RESET_PLL;
                     cnt        <= LD_RST;
                     relock_ack <= 1'b1;
                     pll_rst    <= 1'b1;
                     sdr_reset  <= 1'b1;
                     sys_reset  <= 1'b1;
                     pll_ok     <= 1'b0;
                  end
               end
               FAULT: begin
                  state <= FAULT;
               end
               default: begin
                  state   <= RESET_PLL;
                  cnt     <= LD_RST;
                  pll_rst <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - event scoreboard bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

   logic       clk;
   logic       reset;
   logic       locked;
   logic       relock_req;
   logic       pll_rst;
   logic       sdr_reset;
   logic       sys_reset;
   logic       relock_ack;
   logic       pll_ok;
   logic       fault;
   logic [2:0] retry_count;

   typedef struct {
      int         cyc;
      logic [8:0] v;
   } ev_t;

   ev_t        exp_q[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         t;
   logic [8:0] prev = 'x;

   pll_reset_sequencer #(
      .RST_CYCLES        (4),
      .LOCK_TIMEOUT      (32),
      .STABLE_CYCLES     (8),
      .SDR_TO_SYS_CYCLES (4),
      .MAX_RETRIES       (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .locked      (locked),
      .relock_req  (relock_req),
      .pll_rst     (pll_rst),
      .sdr_reset   (sdr_reset),
      .sys_reset   (sys_reset),
      .relock_ack  (relock_ack),
      .pll_ok      (pll_ok),
      .fault       (fault),
      .retry_count (retry_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [8:0] ov(input logic pr, input logic sdr, input logic sys,
                                     input logic ack, input logic ok, input logic flt,
                                     input int rc);
      logic [2:0] r;
      r = 3'(rc);
      return {pr, sdr, sys, ack, ok, flt, r};
   endfunction

   function automatic void expect_ev(input int c, input logic [8:0] v);
      ev_t e;
      e.cyc = c;
      e.v   = v;
      exp_q.push_back(e);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Every change of the output vector is one DUT event, matched against the next expected one.
   always @(negedge clk) begin
      logic [8:0] cur;
      ev_t        e;
      cur = {pll_rst, sdr_reset, sys_reset, relock_ack, pll_ok, fault, retry_count};
      if (cur !== prev) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cyc=%0d out=%b, required no change", cyc, cur);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.v !== cur) begin
               errors++;
               $display("FAIL output_event: got cyc=%0d out=%b, required cyc=%0d out=%b",
                        cyc, cur, e.cyc, e.v);
            end
         end
         prev = cur;
      end
   end

   initial begin
      reset = 1'b1; locked = 1'b0; relock_req = 1'b0;

      // clean bring-up, locked rises 10 cycles after reset release
      expect_ev(1, ov(1,1,1,0,0,0,0));
      step(2);
      reset = 1'b0;
      t = cyc;
      expect_ev(t+4,  ov(0,1,1,0,0,0,0));
      expect_ev(t+20, ov(0,0,1,0,0,0,0));
      expect_ev(t+24, ov(0,0,0,0,1,0,0));
      step(10);
      locked = 1'b1;
      step(20);

      // relock request in RUN, held through the following non-RUN states
      t = cyc;
      relock_req = 1'b1;
      expect_ev(t+1,  ov(1,1,1,1,0,0,0));
      expect_ev(t+2,  ov(1,1,1,0,0,0,0));
      expect_ev(t+5,  ov(0,1,1,0,0,0,0));
      expect_ev(t+13, ov(0,0,1,0,0,0,0));
      expect_ev(t+17, ov(0,0,0,0,1,0,0));
      step(8);
      relock_req = 1'b0;
      step(12);

      // lock loss in RUN coinciding with a relock request
      t = cyc;
      locked = 1'b0;
      expect_ev(t+3,  ov(1,1,1,0,0,0,1));
      expect_ev(t+7,  ov(0,1,1,0,0,0,1));
      expect_ev(t+15, ov(0,0,1,0,0,0,1));
      expect_ev(t+19, ov(0,0,0,0,1,0,0));
      step(2);
      relock_req = 1'b1;
      step(1);
      relock_req = 1'b0;
      locked = 1'b1;
      step(19);

      // one-cycle lock glitch in STABLE
      t = cyc;
      relock_req = 1'b1;
      expect_ev(t+1,  ov(1,1,1,1,0,0,0));
      expect_ev(t+2,  ov(1,1,1,0,0,0,0));
      expect_ev(t+5,  ov(0,1,1,0,0,0,0));
      expect_ev(t+11, ov(1,1,1,0,0,0,1));
      expect_ev(t+15, ov(0,1,1,0,0,0,1));
      expect_ev(t+23, ov(0,0,1,0,0,0,1));
      expect_ev(t+27, ov(0,0,0,0,1,0,0));
      step(1);
      relock_req = 1'b0;
      step(7);
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(21);

      // reset asserted while in RELEASE_SDR
      t = cyc;
      relock_req = 1'b1;
      expect_ev(t+1,  ov(1,1,1,1,0,0,0));
      expect_ev(t+2,  ov(1,1,1,0,0,0,0));
      expect_ev(t+5,  ov(0,1,1,0,0,0,0));
      expect_ev(t+13, ov(0,0,1,0,0,0,0));
      expect_ev(t+15, ov(1,1,1,0,0,0,0));
      expect_ev(t+19, ov(0,1,1,0,0,0,0));
      expect_ev(t+27, ov(0,0,1,0,0,0,0));
      expect_ev(t+31, ov(0,0,0,0,1,0,0));
      step(1);
      relock_req = 1'b0;
      step(13);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(19);

      // lock never arrives: three pulses, then FAULT until reset
      t = cyc;
      locked = 1'b0;
      reset = 1'b1;
      expect_ev(t+1, ov(1,1,1,0,0,0,0));
      step(2);
      reset = 1'b0;
      t = cyc;
      expect_ev(t+4,   ov(0,1,1,0,0,0,0));
      expect_ev(t+36,  ov(1,1,1,0,0,0,1));
      expect_ev(t+40,  ov(0,1,1,0,0,0,1));
      expect_ev(t+72,  ov(1,1,1,0,0,0,2));
      expect_ev(t+76,  ov(0,1,1,0,0,0,2));
      expect_ev(t+108, ov(1,1,1,0,0,1,2));
      expect_ev(t+131, ov(1,1,1,0,0,0,0));
      expect_ev(t+135, ov(0,1,1,0,0,0,0));
      step(10);
      relock_req = 1'b1;
      step(110);
      relock_req = 1'b0;
      step(10);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(10);

      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: got no change, required cyc=%0d out=%b", e.cyc, e.v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
